// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared fetch FSM encodings, widths and PC step
package instruction_fetch_unit_pkg;
    localparam int INST_WIDTH = 32;
    localparam int ENTRY_WIDTH = 2 * INST_WIDTH;
    localparam logic [31:0] PC_INC = 32'd4;
    typedef enum logic [1:0] {
        FETCH_REQ = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// fetch_fifo: instruction buffer of {pc, inst} entries with flush over push/pop
// Ports: clk, reset (async active-low), flush, push/push_data, pop,
//        count (occupancy), head_valid/head_data (head entry, zero when empty)
module fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic [ENTRY_WIDTH-1:0]  push_data,
    input  logic                    pop,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    head_valid,
    output logic [ENTRY_WIDTH-1:0]  head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [ENTRY_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_pop;
    assign head_valid = count != '0;
    assign head_data = head_valid ? mem[rd_ptr] : '0;
    assign do_pop = pop && head_valid;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch PC, single-outstanding imem requests, buffered instructions
// Ports: clk, reset (async active-low); imem_req_* request channel; imem_resp_* response;
//        redirect_valid/redirect_pc restart; halt gates requests; inst_* decode head
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    input  logic        inst_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_t state;
    logic [31:0] fetch_pc;
    logic [CW-1:0] fifo_count;
    logic accept, push, pop;
    logic [ENTRY_WIDTH-1:0] head;
    // REQ implies nothing outstanding, so only FIFO room matters for issue.
    assign imem_req_valid = reset && state == FETCH_REQ && !halt && fifo_count < CW'(FIFO_DEPTH);
    assign imem_req_addr = fetch_pc;
    assign accept = imem_req_valid && imem_req_ready;
    assign push = state == FETCH_WAIT && imem_resp_valid && !redirect_valid;
    assign pop = inst_valid && inst_ready;
    assign {inst_pc, inst} = head;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= FETCH_REQ;
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            // A request accepted or still in flight now returns stale data.
            state <= state == FETCH_REQ ? (accept ? FETCH_DISCARD : FETCH_REQ)
                                        : (imem_resp_valid ? FETCH_REQ : FETCH_DISCARD);
        end else if (state == FETCH_REQ) begin
            if (accept) begin
                fetch_pc <= fetch_pc + PC_INC;
                state <= FETCH_WAIT;
            end
        end else if (imem_resp_valid) begin
            state <= FETCH_REQ;
        end
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .flush(redirect_valid),
        .push(push),
        .push_data({fetch_pc - PC_INC, imem_resp_data}),
        .pop(pop),
        .count(fifo_count),
        .head_valid(inst_valid),
        .head_data(head)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scenario tasks plus a memory/program-order reference model
module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data;
    logic redirect_valid, halt, inst_valid, inst_ready;
    logic [31:0] redirect_pc, inst_pc, inst;
    int errors = 0, checks = 0;
    bit pend, rnd_ready, stray, last_acc, last_pop;
    int pend_cnt, lat_min, lat_max, n_acc, n_pop;
    logic [31:0] pend_addr, exp_req, exp_pc, last_addr, last_pop_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst), .inst_ready(inst_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1357_0000;
    endfunction

    // One clock: memory answers its outstanding request, then the model checks
    // every request against the sequential/redirected PC stream and every
    // consumed instruction against program order and memory contents.
    task automatic cycle();
        logic redir;
        logic [31:0] tgt;
        imem_resp_valid = stray || (pend && pend_cnt == 0);
        imem_resp_data = stray ? 32'hDEAD_BEEF : mem_word(pend_addr);
        imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        #2;
        redir = redirect_valid;
        tgt = {redirect_pc[31:2], 2'b00};
        last_acc = imem_req_valid && imem_req_ready;
        last_addr = imem_req_addr;
        last_pop = inst_valid && inst_ready && !redir;
        if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req || halt || pend) begin
                errors++;
                $display("FAIL req: addr=%h halt=%b outstanding=%b, required addr=%h with no halt and none outstanding",
                         imem_req_addr, halt, pend, exp_req);
            end
        end
        if (last_pop) begin
            n_pop++;
            last_pop_pc = inst_pc;
            checks++;
            if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL pop: pc=%h inst=%h, required pc=%h inst=%h", inst_pc, inst, exp_pc, mem_word(exp_pc));
            end
            exp_pc += 4;
        end
        if (imem_resp_valid && !stray) pend = 0;
        else if (pend) pend_cnt--;
        if (last_acc) begin
            n_acc++;
            pend = 1;
            pend_addr = imem_req_addr;
            pend_cnt = $urandom_range(lat_min, lat_max);
            exp_req += 4;
        end
        if (redir) begin
            exp_req = tgt;
            exp_pc = tgt;
        end
        stray = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        redirect_valid = 0; redirect_pc = 0; halt = 0; inst_ready = 0; stray = 0;
        pend = 0; pend_cnt = 0; pend_addr = 0; exp_req = RESET_PC; exp_pc = RESET_PC;
        n_acc = 0; n_pop = 0; lat_min = 0; lat_max = 0; rnd_ready = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #2 reset = 1;
    endtask

    task automatic test_reset();
        clear_model();
        imem_req_ready = 1;
        #1 reset = 0;
        #3;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid);
        end
        checks++;
        if ({inst_valid, inst_pc, inst} !== 65'd0) begin
            errors++; $display("FAIL reset_outputs: valid=%b pc=%h inst=%h, required all 0", inst_valid, inst_pc, inst);
        end
        do_reset();
        cycle();
        checks++;
        if (last_acc !== 1'b1 || last_addr !== RESET_PC) begin
            errors++; $display("FAIL first_request: acc=%b addr=%h, required acc=1 addr=%h", last_acc, last_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        inst_ready = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (last_acc !== (k % 2 == 0)) begin
                errors++; $display("FAIL seq_accept[%0d]: got %b, required %b", k, last_acc, k % 2 == 0);
            end
            checks++;
            if (last_pop !== (k >= 2 && k % 2 == 0)) begin
                errors++; $display("FAIL seq_pop[%0d]: got %b, required %b", k, last_pop, k >= 2 && k % 2 == 0);
            end
        end
        checks++;
        if (last_pop_pc !== 32'h8) begin
            errors++; $display("FAIL seq_last_pc: got %h, required 00000008", last_pop_pc);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 1;
        repeat (3) cycle();
        inst_ready = 0;
        repeat (5) cycle();
        checks++;
        if (imem_req_valid !== 1'b0 || n_acc != 3 || inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
            errors++;
            $display("FAIL full_stall: req_valid=%b accepts=%0d inst_valid=%b inst_pc=%h, required 0 3 1 00000004",
                     imem_req_valid, n_acc, inst_valid, inst_pc);
        end
        inst_ready = 1;
        cycle();
        inst_ready = 0;
        cycle();
        checks++;
        if (last_acc !== 1'b1 || last_addr !== 32'hC) begin
            errors++; $display("FAIL resume_after_pop: acc=%b addr=%h, required acc=1 addr=0000000c", last_acc, last_addr);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        cycle();
        cycle();
        lat_min = 1; lat_max = 1;
        cycle();
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++; $display("FAIL redir_prefill: inst_valid=%b, required 1", inst_valid);
        end
        redirect_valid = 1; redirect_pc = 32'h103;
        cycle();
        redirect_valid = 0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL redir_flush: inst_valid=%b, required 0", inst_valid);
        end
        cycle();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL redir_stale_dropped: inst_valid=%b, required 0", inst_valid);
        end
        lat_min = 0; lat_max = 0; inst_ready = 1;
        cycle();
        checks++;
        if (last_acc !== 1'b1 || last_addr !== 32'h100) begin
            errors++; $display("FAIL redir_target_req: acc=%b addr=%h, required acc=1 addr=00000100", last_acc, last_addr);
        end
        cycle();
        cycle();
        checks++;
        if (last_pop !== 1'b1 || last_pop_pc !== 32'h100) begin
            errors++; $display("FAIL redir_target_inst: pop=%b pc=%h, required pop=1 pc=00000100", last_pop, last_pop_pc);
        end
    endtask

    task automatic test_redirect_resp_pop();
        do_reset();
        repeat (3) cycle();
        redirect_valid = 1; redirect_pc = 32'h200; inst_ready = 1;
        cycle();
        redirect_valid = 0; inst_ready = 0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++;
            $display("FAIL redir_resp_pop: inst_valid=%b req_valid=%b addr=%h, required 0 1 00000200",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        n_pop = 0;
        inst_ready = 1;
        repeat (3) cycle();
        checks++;
        if (n_pop != 1 || last_pop_pc !== 32'h200) begin
            errors++; $display("FAIL redir_resp_pop_next: pops=%0d pc=%h, required 1 00000200", n_pop, last_pop_pc);
        end
    endtask

    task automatic test_halt();
        do_reset();
        inst_ready = 1;
        lat_min = 1; lat_max = 1;
        cycle();
        halt = 1;
        cycle();
        cycle();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_drain: inst_valid=%b pc=%h req_valid=%b, required 1 00000000 0", inst_valid, inst_pc, imem_req_valid);
        end
        repeat (4) cycle();
        checks++;
        if (n_acc != 1 || n_pop != 1) begin
            errors++; $display("FAIL halt_quiet: accepts=%0d pops=%0d, required 1 1", n_acc, n_pop);
        end
        halt = 0;
        cycle();
        checks++;
        if (last_acc !== 1'b1 || last_addr !== 32'h4) begin
            errors++; $display("FAIL halt_resume: acc=%b addr=%h, required acc=1 addr=00000004", last_acc, last_addr);
        end
    endtask

    task automatic test_reset_async();
        do_reset();
        cycle();
        cycle();
        lat_min = 2; lat_max = 2;
        cycle();
        cycle();
        checks++;
        if (inst_valid !== 1'b1 || inst !== mem_word(32'h0)) begin
            errors++; $display("FAIL areset_prefill: inst_valid=%b inst=%h, required 1 %h", inst_valid, inst, mem_word(32'h0));
        end
        #2 reset = 0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || {inst_valid, inst_pc, inst} !== 65'd0) begin
            errors++;
            $display("FAIL areset_outputs: req_valid=%b inst_valid=%b pc=%h inst=%h, required all 0",
                     imem_req_valid, inst_valid, inst_pc, inst);
        end
        clear_model();
        @(posedge clk);
        #2 reset = 1;
        stray = 1;
        inst_ready = 1;
        cycle();
        checks++;
        if (last_acc !== 1'b1 || last_addr !== RESET_PC) begin
            errors++; $display("FAIL areset_restart: acc=%b addr=%h, required acc=1 addr=%h", last_acc, last_addr, RESET_PC);
        end
        repeat (3) cycle();
        checks++;
        if (n_pop != 1 || last_pop_pc !== RESET_PC) begin
            errors++; $display("FAIL areset_stray_ignored: pops=%0d pc=%h, required 1 %h", n_pop, last_pop_pc, RESET_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        rnd_ready = 1;
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            inst_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 19) == 0) halt = !halt;
            redirect_valid = $urandom_range(0, 15) == 0;
            redirect_pc = $urandom;
            cycle();
        end
        redirect_valid = 0;
        halt = 0;
        checks++;
        if (n_pop < 100) begin
            errors++; $display("FAIL random_progress: pops=%0d, required at least 100", n_pop);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp_pop();
        test_halt();
        test_reset_async();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
